// File: rtl/change_dispenser.sv
// Purpose: vends the paid item, then pays change greedily (5, 2, 1) to the coin hopper one coin at a time.
// Latency: vend pulse 1 cycle after done; first eject_valid 2 cycles after done; change_done 1 cycle after the last ack.
// Backpressure: holds each coin offered until hopper_ack arrives; no ack for ACK_TIMEOUT cycles latches a fault.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic       product,
    input  logic [3:0] change,
    input  logic       hopper_ack,
    output logic       eject_valid,
    output logic [1:0] eject_coin,
    output logic       vend_valid,
    output logic       vend_item,
    output logic       change_done,
    output logic       busy,
    output logic       overrun,
    output logic       fault
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_EJECT  = 3'd2;
    localparam logic [2:0] ST_FINISH = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    logic [2:0] state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0] eject_coin_q, eject_coin_d;
    logic       vend_valid_q, vend_valid_d;
    logic       vend_item_q, vend_item_d;
    logic       overrun_q, overrun_d;

    logic [3:0] coin_value;
    logic [3:0] remaining_after;

    // Value of the coin currently offered, and what is left once it is taken.
    always_comb begin
        coin_value = 4'd1;
        case (eject_coin_q)
            COIN_5:  coin_value = 4'd5;
            COIN_2:  coin_value = 4'd2;
            default: coin_value = 4'd1;
        endcase
        // Greedy selection never offers more than remaining, so this cannot wrap.
        remaining_after = remaining_q - coin_value;
    end

    // Next-state and datapath update for the payout sequencer.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        tmo_cnt_d    = tmo_cnt_q;
        eject_coin_d = eject_coin_q;
        vend_valid_d = 1'b0;
        vend_item_d  = vend_item_q;
        // A done outside IDLE is dropped; remember that it happened.
        overrun_d    = overrun_q | (done && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    remaining_d  = change;
                    vend_valid_d = 1'b1;
                    vend_item_d  = product;
                    state_d      = (change != 4'd0) ? ST_SELECT : ST_FINISH;
                end
            end
            ST_SELECT: begin
                if (remaining_q >= 4'd5)      eject_coin_d = COIN_5;
                else if (remaining_q >= 4'd2) eject_coin_d = COIN_2;
                else                          eject_coin_d = COIN_1;
                tmo_cnt_d = 8'd0;
                state_d   = ST_EJECT;
            end
            ST_EJECT: begin
                if (hopper_ack) begin
                    remaining_d  = remaining_after;
                    eject_coin_d = COIN_NONE;
                    state_d      = (remaining_after != 4'd0) ? ST_SELECT : ST_FINISH;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    // An ack on this last cycle would have taken the branch above.
                    eject_coin_d = COIN_NONE;
                    state_d      = ST_FAULT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                // Jammed hopper: only reset recovers.
                eject_coin_d = COIN_NONE;
            end
            default: begin
                state_d      = ST_IDLE;
                eject_coin_d = COIN_NONE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any payout in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 4'd0;
            tmo_cnt_q    <= 8'd0;
            eject_coin_q <= COIN_NONE;
            vend_valid_q <= 1'b0;
            vend_item_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            tmo_cnt_q    <= tmo_cnt_d;
            eject_coin_q <= eject_coin_d;
            vend_valid_q <= vend_valid_d;
            vend_item_q  <= vend_item_d;
            overrun_q    <= overrun_d;
        end
    end

    assign eject_valid = (state_q == ST_EJECT);
    assign eject_coin  = eject_coin_q;
    assign vend_valid  = vend_valid_q;
    assign vend_item   = vend_item_q;
    assign change_done = (state_q == ST_FINISH);
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;
    assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vend pulse, greedy payout, timeout fault, overrun, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge before inputs move.
// Hopper acknowledgement delays are chosen per coin to exercise the valid/ack handshake.
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       done;
    logic       product;
    logic [3:0] change;
    logic       hopper_ack;
    logic       eject_valid;
    logic [1:0] eject_coin;
    logic       vend_valid;
    logic       vend_item;
    logic       change_done;
    logic       busy;
    logic       overrun;
    logic       fault;

    int checks;
    int errors;

    change_dispenser #(.ACK_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .product     (product),
        .change      (change),
        .hopper_ack  (hopper_ack),
        .eject_valid (eject_valid),
        .eject_coin  (eject_coin),
        .vend_valid  (vend_valid),
        .vend_item   (vend_item),
        .change_done (change_done),
        .busy        (busy),
        .overrun     (overrun),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every output must be zero (reset / idle-after-reset view).
    task automatic chk_all_zero(input string tag);
        chk({tag, ".eject_valid"}, 8'(eject_valid), 8'd0);
        chk({tag, ".eject_coin"},  8'(eject_coin),  8'd0);
        chk({tag, ".vend_valid"},  8'(vend_valid),  8'd0);
        chk({tag, ".vend_item"},   8'(vend_item),   8'd0);
        chk({tag, ".change_done"}, 8'(change_done), 8'd0);
        chk({tag, ".busy"},        8'(busy),        8'd0);
        chk({tag, ".overrun"},     8'(overrun),     8'd0);
        chk({tag, ".fault"},       8'(fault),       8'd0);
    endtask

    // Wait (bounded) for a coin offer, hold ack off for 'delay' cycles, then ack it.
    // Returns at the falling edge right after the acking clock edge.
    task automatic pay_coin(input string tag, input logic [1:0] exp_coin, input int delay);
        int n;
        n = 0;
        while (!eject_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, ".valid"}, 8'(eject_valid), 8'd1);
        chk({tag, ".coin"},  8'(eject_coin),  8'(exp_coin));
        for (int i = 0; i < delay; i++) begin
            step();
            chk({tag, ".hold_valid"}, 8'(eject_valid), 8'd1);
            chk({tag, ".hold_coin"},  8'(eject_coin),  8'(exp_coin));
        end
        hopper_ack = 1'b1;
        step();
        hopper_ack = 1'b0;
        chk({tag, ".gap_valid"}, 8'(eject_valid), 8'd0);
        chk({tag, ".gap_coin"},  8'(eject_coin),  8'd0);
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        done       = 1'b0;
        product    = 1'b0;
        change     = 4'd0;
        hopper_ack = 1'b0;

        // Reset state.
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();
        chk_all_zero("post_reset");

        // change=8, drink: coins 5, 2, 1 with one-cycle ack delay.
        done = 1'b1; change = 4'd8; product = 1'b1;
        step();
        done = 1'b0;
        chk("t1.vend_valid", 8'(vend_valid), 8'd1);
        chk("t1.vend_item",  8'(vend_item),  8'd1);
        chk("t1.busy",       8'(busy),       8'd1);
        chk("t1.select_gap", 8'(eject_valid), 8'd0);
        step();
        chk("t1.latency_valid", 8'(eject_valid), 8'd1);
        chk("t1.vend_pulse_end", 8'(vend_valid), 8'd0);
        pay_coin("t1.c5", 2'b11, 1);
        chk("t1.no_done_early", 8'(change_done), 8'd0);
        pay_coin("t1.c2", 2'b10, 1);
        pay_coin("t1.c1", 2'b01, 1);
        chk("t1.change_done", 8'(change_done), 8'd1);
        chk("t1.busy_finish", 8'(busy), 8'd1);
        step();
        chk("t1.change_done_once", 8'(change_done), 8'd0);
        chk("t1.busy_low", 8'(busy), 8'd0);
        chk("t1.item_held", 8'(vend_item), 8'd1);

        // change=0, chocolate: vend and change_done together, no coins.
        done = 1'b1; change = 4'd0; product = 1'b0;
        step();
        done = 1'b0;
        chk("t2.vend_valid",  8'(vend_valid),  8'd1);
        chk("t2.vend_item",   8'(vend_item),   8'd0);
        chk("t2.change_done", 8'(change_done), 8'd1);
        chk("t2.no_eject",    8'(eject_valid), 8'd0);
        step();
        chk("t2.idle",        8'(busy),        8'd0);
        chk("t2.no_eject2",   8'(eject_valid), 8'd0);
        chk("t2.vend_end",    8'(vend_valid),  8'd0);

        // change=15: three 5-unit coins with ack delays 0, 3, 7.
        done = 1'b1; change = 4'd15; product = 1'b1;
        step();
        done = 1'b0;
        pay_coin("t3.c5a", 2'b11, 0);
        pay_coin("t3.c5b", 2'b11, 3);
        pay_coin("t3.c5c", 2'b11, 7);
        chk("t3.change_done", 8'(change_done), 8'd1);
        step();
        chk("t3.busy_low",  8'(busy),        8'd0);
        chk("t3.no_extra",  8'(eject_valid), 8'd0);

        // change=4, hopper never acks: fault after exactly 15 valid cycles.
        done = 1'b1; change = 4'd4; product = 1'b0;
        step();
        done = 1'b0;
        step();
        n = 0;
        while (eject_valid && n < 40) begin
            chk("t4.coin_stable", 8'(eject_coin), 8'b10);
            n++;
            step();
        end
        chk("t4.valid_cycles", 8'(n), 8'd15);
        chk("t4.fault",        8'(fault),       8'd1);
        chk("t4.valid_low",    8'(eject_valid), 8'd0);
        chk("t4.coin_zero",    8'(eject_coin),  8'd0);
        chk("t4.busy",         8'(busy),        8'd1);
        chk("t4.no_overrun",   8'(overrun),     8'd0);
        done = 1'b1; change = 4'd3;
        step();
        done = 1'b0;
        chk("t4.overrun",      8'(overrun),    8'd1);
        chk("t4.no_vend",      8'(vend_valid), 8'd0);
        hopper_ack = 1'b1;
        step();
        step();
        hopper_ack = 1'b0;
        chk("t4.stay_fault",   8'(fault),       8'd1);
        chk("t4.stay_novalid", 8'(eject_valid), 8'd0);
        rst = 1'b0;
        #1;
        chk_all_zero("t4.reset");
        step();
        rst = 1'b1;
        step();

        // change=7 with a second done mid-payout: overrun, payout unchanged (5 then 2).
        done = 1'b1; change = 4'd7; product = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("t5.valid", 8'(eject_valid), 8'd1);
        done = 1'b1; change = 4'd3; product = 1'b0;
        step();
        done = 1'b0;
        chk("t5.overrun",   8'(overrun),    8'd1);
        chk("t5.no_revend", 8'(vend_valid), 8'd0);
        pay_coin("t5.c5", 2'b11, 0);
        pay_coin("t5.c2", 2'b10, 1);
        chk("t5.change_done", 8'(change_done), 8'd1);
        step();
        chk("t5.busy_low",   8'(busy),        8'd0);
        chk("t5.no_extra",   8'(eject_valid), 8'd0);
        chk("t5.item_kept",  8'(vend_item),   8'd1);
        chk("t5.overrun_sticky", 8'(overrun), 8'd1);

        // change=9, reset during the second coin, then change=1.
        done = 1'b1; change = 4'd9; product = 1'b1;
        step();
        done = 1'b0;
        pay_coin("t6.c5", 2'b11, 0);
        step();
        chk("t6.second_valid", 8'(eject_valid), 8'd1);
        chk("t6.second_coin",  8'(eject_coin),  8'b10);
        rst = 1'b0;
        #1;
        chk_all_zero("t6.reset");
        step();
        rst = 1'b1;
        step();
        done = 1'b1; change = 4'd1; product = 1'b0;
        step();
        done = 1'b0;
        chk("t6.vend_valid", 8'(vend_valid), 8'd1);
        chk("t6.vend_item",  8'(vend_item),  8'd0);
        pay_coin("t6.c1", 2'b01, 2);
        chk("t6.change_done", 8'(change_done), 8'd1);
        step();
        chk("t6.busy_low",   8'(busy),        8'd0);
        chk("t6.no_extra",   8'(eject_valid), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending controller. Consumes its one-cycle `done` pulse with the `product` and `change[3:0]` values, issues a one-cycle vend command for the product, then pays the change out to the coin hopper. Payout is one coin at a time, largest denomination first (5, 2, 1), using a valid/ack handshake. A hopper jam is detected by timeout and latched as a fault.

## Interface
Parameters:
- ACK_TIMEOUT, 15: number of consecutive `eject_valid` cycles without `hopper_ack` before entering FAULT (legal range 2..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset. The clock is single; reset is asynchronous and active-low.
- done  in  1  one-cycle transaction-complete pulse from the vending controller.
- product  in  1  item paid for, sampled with `done`: 1 = drink, 0 = chocolate.
- change  in  4  change owed in units, sampled with `done`; range 0..15.
- hopper_ack  in  1  hopper has taken the coin currently offered.
- eject_valid  out  1  a coin request is being offered to the hopper.
- eject_coin  out  2  coin code offered: 2'b01 = 1 unit, 2'b10 = 2, 2'b11 = 5; 2'b00 when idle.
- vend_valid  out  1  one-cycle pulse commanding the item release.
- vend_item  out  1  item for `vend_valid`; holds its value until the next vend.
- change_done  out  1  one-cycle pulse when payout is complete, including the zero-change case.
- busy  out  1  high in every state except IDLE, including FAULT.
- overrun  out  1  sticky; set when `done` arrives while busy.
- fault  out  1  sticky; set on hopper timeout.

## Operation
- All outputs are registered or decoded from the state register.
- Reset values: every output is 0, `remaining` = 0, the timeout counter is 0, and the state is IDLE.
- Internal registers: `remaining[3:0]` and a timeout counter of 8 bits.
- States:
  - IDLE: on `done`, set `remaining` <= `change`, `vend_valid` <= 1, and `vend_item` <= `product`. Go to SELECT if `change` != 0, else to FINISH.
  - SELECT: set `eject_coin` <= 11 if `remaining` >= 5, else 10 if `remaining` >= 2, else 01. Clear the timeout counter. Go to EJECT.
  - EJECT: `eject_valid` = 1 and `eject_coin` is held stable.
    - If `hopper_ack` is high: subtract the coin value from `remaining`, drive `eject_coin` to 00, and go to SELECT if the new `remaining` != 0, else to FINISH.
    - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1 and `hopper_ack` is still low, go to FAULT.
  - FINISH: `change_done` = 1 for one cycle, then go to IDLE.
  - FAULT: `fault` = 1, `eject_valid` = 0, `eject_coin` = 00. The block stays in FAULT until reset; `done` is ignored apart from setting `overrun`.
- Arithmetic: `remaining` never underflows, because greedy selection never picks a coin larger than `remaining`.
- `hopper_ack` outside EJECT is ignored.
- `done` in any state other than IDLE is dropped and sets `overrun`. The sticky flags clear only on reset.
- Reset mid-payout abandons the remaining change immediately; the partially paid amount is not recorded.

## Timing
- `done` sampled at edge E0:
  - `vend_valid` is high for the cycle after E0, together with SELECT.
  - The first `eject_valid` rises after E0+1, so latency is 2 cycles.
- `hopper_ack` sampled at edge A:
  - `eject_valid` falls after A, leaving at least one low cycle (SELECT) between coins.
  - The next coin is valid after A+1.
- Last ack at edge A: `change_done` is high in the cycle after A, and `busy` falls after A+1.
- Zero change: `change_done` is high in the cycle after E0, and the block is back in IDLE after E0+1.
- Timeout: with no ack, `eject_valid` stays high for exactly ACK_TIMEOUT cycles, then `fault` rises and `eject_valid` falls on the same edge.
- An ack in the final (ACK_TIMEOUT-th) cycle wins over the fault.
- Back-to-back transactions: `done` may be accepted in the cycle after `change_done`, once the block is back in IDLE.

## Test plan
- Reset, then `done` with `change`=8 and `product`=1, hopper acking 1 cycle after each valid:
  - `vend_valid`/`vend_item`=1 at E0+1.
  - Coins 11, 10, 01 are issued in order.
  - `change_done` pulses once.
  - `busy` is low 2 cycles after the last ack.
- `change`=0 and `product`=0: no `eject_valid`; `vend_valid` and `change_done` both pulse in the cycle after E0 (vend item = 0).
- `change`=15 with ack delays of 0, 3 and 7 cycles: exactly three 11 coins are issued, `eject_coin` stays stable while valid, and each coin is followed by a valid-low gap.
- `change`=4 with `hopper_ack` held low: `fault`=1 after 15 valid cycles, `eject_valid` goes to 0, and a later `done` sets `overrun` while the block stays in FAULT. Reset clears everything.
- `done` (change=7) pulsed again during payout: `overrun`=1, and the first payout completes with 5 then 2 and no extra coins.
- Assert reset mid-payout (change=9, after the first coin): all outputs are 0 immediately. After release, a new `done` with change=1 yields a single 01 coin.
